// File: rtl/country_car_sensor.sv
// country_car_sensor: debounced country-road car queue producing the car-waiting request X
module country_car_sensor #(
  parameter int DEB       = 4,
  parameter int PASS_CYC  = 8,
  parameter int MAX_GREEN = 32,
  parameter int STUCK     = 64,
  parameter int CW        = 4
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          sense_raw,
  input  logic          cntry_green,
  output logic          X,
  output logic [CW-1:0] car_count,
  output logic          sensor_fault
);
  localparam int DW = $clog2(DEB + 1);
  localparam int PW = $clog2(PASS_CYC + 1);
  localparam int GW = $clog2(MAX_GREEN + 1);
  localparam int FW = $clog2(STUCK + 1);
  typedef enum logic [1:0] {IDLE, REQ, SERVE, YIELD} state_t;
  state_t state, state_nx;
  logic s1, s2, deb, deb_q;
  logic [DW-1:0] deb_cnt;
  logic [PW-1:0] pass_tmr;
  logic [GW-1:0] grn_tmr;
  logic [FW-1:0] flt_tmr;
  logic arrival, departure, pass_wrap, full;
  assign arrival      = deb & ~deb_q;
  assign pass_wrap    = (state == SERVE) && (pass_tmr == PW'(PASS_CYC - 1));
  assign departure    = pass_wrap && (car_count != '0);
  assign full         = &car_count;
  assign sensor_fault = flt_tmr == FW'(STUCK);
  assign X            = (state == REQ) || (state == SERVE);
  // two-flop synchroniser for the asynchronous loop detector
  always_ff @(posedge clk) begin
    if (!clear) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sense_raw;
      s2 <= s1;
    end
  end
  // debounce: flip only after DEB consecutive cycles of disagreement
  always_ff @(posedge clk) begin
    if (!clear) begin
      deb     <= 1'b0;
      deb_q   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      deb_q <= deb;
      if (s2 == deb) deb_cnt <= '0;
      else if (deb_cnt == DW'(DEB - 1)) begin
        deb     <= ~deb;
        deb_cnt <= '0;
      end else deb_cnt <= deb_cnt + 1'b1;
    end
  end
  // each PASS_CYC cycles of service counts as one departing car
  always_ff @(posedge clk) begin
    if (!clear || state != SERVE) pass_tmr <= '0;
    else pass_tmr <= pass_wrap ? '0 : pass_tmr + 1'b1;
  end
  // queue depth: saturates high, simultaneous arrival and departure cancel
  always_ff @(posedge clk) begin
    if (!clear) car_count <= '0;
    else if (arrival && !departure && !full) car_count <= car_count + 1'b1;
    else if (departure && !arrival) car_count <= car_count - 1'b1;
  end
  // consecutive SERVE cycles, bounding how long the country side keeps green
  always_ff @(posedge clk) begin
    if (!clear) grn_tmr <= '0;
    else grn_tmr <= (state == SERVE) ? grn_tmr + 1'b1 : '0;
  end
  // stuck-high detector on the debounced level, saturating at STUCK
  always_ff @(posedge clk) begin
    if (!clear || !deb) flt_tmr <= '0;
    else if (flt_tmr != FW'(STUCK)) flt_tmr <= flt_tmr + 1'b1;
  end
  // state register
  always_ff @(posedge clk) begin
    state <= !clear ? IDLE : state_nx;
  end
  // next-state logic; queue drain wins over the max-green cap
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = (car_count != '0) ? REQ : IDLE;
      REQ:   state_nx = cntry_green ? SERVE : REQ;
      SERVE: begin
        if (car_count == '0 && !arrival) state_nx = IDLE;
        else if (grn_tmr == GW'(MAX_GREEN - 1)) state_nx = YIELD;
        else if (!cntry_green) state_nx = (car_count != '0) ? REQ : IDLE;
      end
      YIELD: if (!cntry_green) state_nx = (car_count != '0) ? REQ : IDLE;
    endcase
  end
endmodule

// File: tb/tb_country_car_sensor.sv
// tb_country_car_sensor: directed checks of debounce, queueing, max-green and fault behaviour
module tb_country_car_sensor;
  logic clk = 1'b0;
  logic clear, sense_raw, cntry_green;
  logic X, sensor_fault;
  logic [3:0] car_count;
  int compared = 0;
  int mismatched = 0;
  country_car_sensor dut (
    .clk(clk), .clear(clear), .sense_raw(sense_raw), .cntry_green(cntry_green),
    .X(X), .car_count(car_count), .sensor_fault(sensor_fault)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic car();
    sense_raw = 1'b1;
    step(8);
    sense_raw = 1'b0;
    step(8);
  endtask
  task automatic do_reset();
    clear = 1'b0;
    step(1);
    clear = 1'b1;
  endtask
  initial begin
    clear = 1'b0;
    sense_raw = 1'b1;
    cntry_green = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_x", X, 0);
      chk("rst_cnt", car_count, 0);
      chk("rst_flt", sensor_fault, 0);
    end
    clear = 1'b1;
    sense_raw = 1'b0;
    step(8);
    sense_raw = 1'b1;
    step(3);
    sense_raw = 1'b0;
    step(10);
    chk("glitch_cnt", car_count, 0);
    chk("glitch_x", X, 0);
    sense_raw = 1'b1;
    step(6);
    chk("car_cnt_e5", car_count, 0);
    step(1);
    chk("car_cnt_e6", car_count, 1);
    chk("car_x_e6", X, 0);
    step(1);
    chk("car_x_e7", X, 1);
    step(2);
    sense_raw = 1'b0;
    step(8);
    cntry_green = 1'b1;
    step(1);
    chk("serve_x", X, 1);
    step(7);
    chk("serve_cnt_7", car_count, 1);
    step(1);
    chk("serve_cnt_8", car_count, 0);
    chk("serve_x_8", X, 1);
    step(1);
    chk("drain_x", X, 0);
    cntry_green = 1'b0;
    step(2);
    for (int i = 0; i < 10; i++) car();
    chk("q10_cnt", car_count, 10);
    chk("q10_x", X, 1);
    cntry_green = 1'b1;
    step(1);
    step(31);
    chk("mg31_x", X, 1);
    chk("mg31_cnt", car_count, 7);
    step(1);
    chk("mg32_x", X, 0);
    chk("mg32_cnt", car_count, 6);
    cntry_green = 1'b0;
    step(1);
    chk("yield_req_x", X, 1);
    chk("yield_cnt", car_count, 6);
    cntry_green = 1'b1;
    step(2);
    sense_raw = 1'b1;
    step(6);
    chk("sim_cnt_7", car_count, 6);
    step(1);
    chk("sim_cnt_8", car_count, 6);
    step(1);
    sense_raw = 1'b0;
    cntry_green = 1'b0;
    step(8);
    do_reset();
    for (int i = 0; i < 16; i++) car();
    chk("sat_cnt", car_count, 15);
    chk("sat_x", X, 1);
    do_reset();
    step(4);
    sense_raw = 1'b1;
    step(69);
    chk("flt_e68", sensor_fault, 0);
    step(1);
    chk("flt_e69", sensor_fault, 1);
    step(10);
    sense_raw = 1'b0;
    step(6);
    chk("flt_e85", sensor_fault, 1);
    step(1);
    chk("flt_e86", sensor_fault, 0);
    chk("flt_cnt", car_count, 1);
    cntry_green = 1'b1;
    step(1);
    chk("mid_serve_x", X, 1);
    clear = 1'b0;
    step(1);
    chk("mid_rst_x", X, 0);
    chk("mid_rst_cnt", car_count, 0);
    chk("mid_rst_flt", sensor_fault, 0);
    clear = 1'b1;
    cntry_green = 1'b0;
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
